seven_seg_scan: RTL and testbench
=================================

// Module: seven_seg_scan
// PURPOSE
//   Time-multiplexed driver for NUM_DIGITS common-anode hex digits on a shared segment bus.
//   Holds a shadow copy of the displayed value, loaded on a strobe, and scans one digit per
//   refresh period. Optional leading-zero suppression and global display enable.
//   Sits between the processor output register and the board display pins.
// PARAMETERS
//   NUM_DIGITS   4      digits driven, legal 1..8
//   REFRESH_DIV  50000  clk cycles each digit stays lit, legal >= 2
//   ACTIVE_LOW   1      1: seg/an asserted low; 0: asserted high
// PORTS
//   clk       in   1              rising-edge clock
//   rst       in   1              asynchronous, active-high reset
//   load      in   1              capture value into shadow register this edge
//   value     in   4*NUM_DIGITS   nibble i (value[4i+3:4i]) drives digit i; digit 0 = rightmost
//   blank_lz  in   1              1: suppress leading zeros
//   enable    in   1              0: display dark, scan frozen
//   seg       out  7              segments {g,f,e,d,c,b,a} = seg[6:0], registered
//   an        out  NUM_DIGITS     digit select, one-hot when lit, registered
//   digit_idx out  $clog2(NUM_DIGITS) (min 1)  index currently lit, registered
// BEHAVIOUR
// - Reset (async, while rst=1): shadow=0, div_cnt=0, idx=0, digit_idx=0, seg=all-off,
//   an=all-off. "off" = 1s when ACTIVE_LOW=1, 0s otherwise.
// - Shadow: load=1 at edge t -> shadow=value after t. First visible on seg at edge t+1.
//   load is independent of enable; loads while disabled are kept.
// - Divider: when enable=1, div_cnt increments every cycle. At REFRESH_DIV-1 it wraps to 0
//   and idx advances. idx wraps NUM_DIGITS-1 -> 0. NUM_DIGITS=1: idx stays 0.
// - enable=0: div_cnt and idx hold. seg and an go all-off at the next edge.
//   When enable returns to 1, the scan resumes from the held idx and div_cnt.
// - Output register: each edge with enable=1, an=onehot(idx), digit_idx=idx,
//   seg=glyph(shadow nibble idx), computed from the pre-edge idx and shadow.
//   Latency: 1 cycle after an idx change.
// - Ghost blanking: on the edge where idx advances, seg is forced all-off for that one cycle.
//   an already shows the new digit in that cycle.
// - Leading-zero suppression: when blank_lz=1, digit i>0 is blank (seg all-off, an still
//   asserted) if nibbles NUM_DIGITS-1..i are all 0. Digit 0 is never suppressed, so a
//   value of 0 shows "0".
// - Glyph table, active-high {g..a}, inverted when ACTIVE_LOW=1:
//   0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:67 A:77 b:7C C:39 d:5E E:79 F:71
// - Illegal parameters produce an elaboration-time $error.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1 unless stated)
// - rst pulse mid-scan, asynchronous to clk -> seg=7F and an=F immediately; shadow=0.
// - load value=16'h12AF, enable=1 -> an cycles E,D,B,7, each held 4 clk.
//   seg = ~06 on an=7, ~5B on an=B, ~77 on an=D, ~71 on an=E, seg=7F in each switch cycle.
// - blank_lz=1, value=16'h0030 -> digits 3 and 2 dark (seg=7F), digit 1 seg=~4F,
//   digit 0 seg=~3F. value=0 -> only digit 0 lit, showing ~3F.
// - enable=0 for 10 cycles mid-digit -> seg=7F and an=F from the next edge.
//   On re-enable, the same digit resumes with its remaining dwell count.
// - load on the same edge that idx advances -> blank cycle, then the new nibble appears.
//   No stale glyph is ever shown on the new digit.
// - ACTIVE_LOW=0, NUM_DIGITS=1, value=4'h9 -> an=1 constant, seg=67 except the blank
//   cycle at each div_cnt wrap.

Source files
------------

// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - display driver bus between processor-side register and pins
//   load      master->slave  capture value into the shadow register
//   value     master->slave  4*NUM_DIGITS nibbles, nibble 0 = rightmost digit
//   blank_lz  master->slave  suppress leading zeros
//   enable    master->slave  0 darkens the display and freezes the scan
//   seg       slave->master  segments {g,f,e,d,c,b,a}
//   an        slave->master  digit select, one-hot when lit
//   digit_idx slave->master  index of the digit currently lit
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
) ();
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    blank_lz;
    logic                    enable;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;

    modport master (
        output load, value, blank_lz, enable,
        input  seg, an, digit_idx
    );

    modport slave (
        input  load, value, blank_lz, enable,
        output seg, an, digit_idx
    );
endinterface

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed hex driver for common-anode seven-segment digits
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  seven_seg_scan_if.slave: load/value/blank_lz/enable in, seg/an/digit_idx out
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic            clk,
    input  logic            rst,
    seven_seg_scan_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam bit                    INVERT   = (ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF  = INVERT ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = INVERT ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
            $error("seven_seg_scan: NUM_DIGITS must be in 1..8");
        end
        if (REFRESH_DIV < 2) begin : g_bad_refresh_div
            $error("seven_seg_scan: REFRESH_DIV must be >= 2");
        end
        if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_active_low
            $error("seven_seg_scan: ACTIVE_LOW must be 0 or 1");
        end
    endgenerate

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    blank_q, blank_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;

    logic                    advance;
    logic [3:0]              cur_nib;
    logic                    upper_zero;
    logic                    cur_upper_zero;
    logic                    suppress;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [6:0]              seg_ah;

    // Active-high glyphs, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h67;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Shadow register and scan divider.
    always_comb begin
        shadow_d  = bus.load ? bus.value : shadow_q;
        advance   = bus.enable && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        if (bus.enable) begin
            div_cnt_d = advance ? '0 : div_cnt_q + DIV_W'(1);
        end
        if (advance) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        // One blank cycle follows every divider wrap so the previous digit's
        // segments never ghost onto the newly selected anode.
        blank_d = advance;
    end

    // Digit selection: walk from the leftmost digit down, tracking whether all
    // nibbles at or above the current position are zero.
    always_comb begin
        cur_nib        = 4'h0;
        upper_zero     = 1'b1;
        cur_upper_zero = 1'b0;
        an_onehot      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                cur_nib        = shadow_q[4*i +: 4];
                cur_upper_zero = upper_zero;
                an_onehot[i]   = 1'b1;
            end
        end
        // Digit 0 is never suppressed so a zero value still shows "0".
        suppress = bus.blank_lz && (idx_q != '0) && cur_upper_zero;
        seg_ah   = (blank_q || suppress) ? 7'h00 : glyph(cur_nib);
    end

    // Output register; digit_idx holds its last lit index while disabled.
    always_comb begin
        seg_d       = SEG_OFF;
        an_d        = AN_OFF;
        digit_idx_d = digit_idx_q;
        if (bus.enable) begin
            seg_d       = INVERT ? ~seg_ah : seg_ah;
            an_d        = INVERT ? ~an_onehot : an_onehot;
            digit_idx_d = idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= '0;
            div_cnt_q   <= '0;
            idx_q       <= '0;
            blank_q     <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
            digit_idx_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            blank_q     <= blank_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.digit_idx = digit_idx_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - scoreboard bench for seven_seg_scan (4-digit active-low, 1-digit active-high)
module tb_seven_seg_scan;
    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] an;
        logic [2:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_if #(.NUM_DIGITS(4)) bus_a ();
    seven_seg_scan_if #(.NUM_DIGITS(1)) bus_b ();

    seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    seven_seg_scan #(.NUM_DIGITS(1), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int P_ND [2] = '{4, 1};
    int P_RD [2] = '{4, 4};
    int P_AL [2] = '{1, 0};

    logic [63:0] m_shadow [2];
    int          m_cnt    [2];
    int          m_idx    [2];
    int          m_last   [2];
    bit          m_wrap   [2];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_shadow[k] = '0;
            m_cnt[k]    = 0;
            m_idx[k]    = 0;
            m_last[k]   = 0;
            m_wrap[k]   = 1'b0;
        end
    endtask

    // Result of the coming clock edge for display k, then advance the model.
    task automatic model_step(input int k, input bit ld, input logic [63:0] val,
                              input bit blz, input bit en, output exp_t e);
        logic [63:0] upper;
        logic [6:0]  g;
        logic [7:0]  onehot;
        logic [7:0]  all_on;
        int          nd;
        nd     = P_ND[k];
        all_on = 8'((1 << nd) - 1);
        if (en) begin
            upper = m_shadow[k] >> (4 * m_idx[k]);
            if (m_wrap[k])
                g = 7'h00;
            else if (blz && m_idx[k] > 0 && upper == 64'd0)
                g = 7'h00;
            else
                g = glyph_tbl[upper[3:0]];
            onehot    = 8'(1 << m_idx[k]);
            e.seg     = (P_AL[k] != 0) ? ~g : g;
            e.an      = (P_AL[k] != 0) ? (all_on & ~onehot) : onehot;
            e.idx     = 3'(m_idx[k]);
            m_last[k] = m_idx[k];
        end else begin
            e.seg = (P_AL[k] != 0) ? 7'h7F : 7'h00;
            e.an  = (P_AL[k] != 0) ? all_on : 8'h00;
            e.idx = 3'(m_last[k]);
        end
        if (ld) m_shadow[k] = val & ((64'd1 << (4 * nd)) - 64'd1);
        if (en) begin
            if (m_cnt[k] == P_RD[k] - 1) begin
                m_cnt[k]  = 0;
                m_idx[k]  = (m_idx[k] + 1) % nd;
                m_wrap[k] = 1'b1;
            end else begin
                m_cnt[k]  = m_cnt[k] + 1;
                m_wrap[k] = 1'b0;
            end
        end else begin
            m_wrap[k] = 1'b0;
        end
    endtask

    task automatic drive_push(input bit ld, input logic [15:0] val, input bit blz, input bit en);
        exp_t e;
        bus_a.load     = ld;
        bus_a.value    = val;
        bus_a.blank_lz = blz;
        bus_a.enable   = en;
        bus_b.load     = ld;
        bus_b.value    = val[3:0];
        bus_b.blank_lz = blz;
        bus_b.enable   = en;
        model_step(0, ld, 64'(val), blz, en, e);
        qa.push_back(e);
        model_step(1, ld, 64'(val), blz, en, e);
        qb.push_back(e);
    endtask

    task automatic step(input bit ld, input logic [15:0] val, input bit blz, input bit en);
        @(negedge clk);
        #1;
        drive_push(ld, val, blz, en);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_seg"}, int'(bus_a.seg), 'h7F);
        chk({tag, "_a_an"}, int'(bus_a.an), 'hF);
        chk({tag, "_a_idx"}, int'(bus_a.digit_idx), 0);
        chk({tag, "_b_seg"}, int'(bus_b.seg), 'h00);
        chk({tag, "_b_an"}, int'(bus_b.an), 'h0);
    endtask

    task automatic random_phase(input int n);
        bit          blz;
        logic [15:0] v;
        blz = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 31) == 0) blz = ~blz;
            v = 16'($urandom) >> $urandom_range(0, 15);
            step($urandom_range(0, 3) == 0, v, blz, $urandom_range(0, 7) != 0);
        end
    endtask

    // Monitor: every edge carries one scoreboard entry per display while out of reset.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_seg", int'(bus_a.seg), int'(e.seg));
            chk("a_an", int'(bus_a.an), int'(e.an));
            chk("a_idx", int'(bus_a.digit_idx), int'(e.idx));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_seg", int'(bus_b.seg), int'(e.seg));
            chk("b_an", int'(bus_b.an), int'(e.an));
            chk("b_idx", int'(bus_b.digit_idx), int'(e.idx));
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        bus_a.load = 1'b0; bus_a.value = '0; bus_a.blank_lz = 1'b0; bus_a.enable = 1'b0;
        bus_b.load = 1'b0; bus_b.value = '0; bus_b.blank_lz = 1'b0; bus_b.enable = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");

        @(negedge clk);
        #1;
        rst = 1'b0;
        drive_push(1'b1, 16'h12AF, 1'b0, 1'b1);
        repeat (40) step(1'b0, 16'h0000, 1'b0, 1'b1);

        step(1'b1, 16'h0030, 1'b1, 1'b1);
        repeat (20) step(1'b0, 16'h0000, 1'b1, 1'b1);
        step(1'b1, 16'h0000, 1'b1, 1'b1);
        repeat (20) step(1'b0, 16'h0000, 1'b1, 1'b1);

        step(1'b1, 16'h12AF, 1'b0, 1'b1);
        repeat (5) step(1'b0, 16'h0000, 1'b0, 1'b1);
        repeat (10) step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h9C3E, 1'b0, 1'b0);
        repeat (24) step(1'b0, 16'h0000, 1'b0, 1'b1);

        random_phase(600);

        // Asynchronous reset in the middle of the scan, away from any edge.
        @(posedge clk);
        #3;
        bus_a.load = 1'b0; bus_b.load = 1'b0;
        rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst_hold");
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive_push(1'b0, 16'h0000, 1'b0, 1'b1);
        repeat (16) step(1'b0, 16'h0000, 1'b0, 1'b1);

        random_phase(300);

        for (int i = 0; i < 5 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        checks++;
        if (qa.size() > 0 || qb.size() > 0) begin
            errors++;
            $display("FAIL drain pending_a=%0d pending_b=%0d expected=0", qa.size(), qb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
